// File: rtl/control_unit_if.sv
// Control bundle between the control unit (master) and the datapath (slave):
// instruction/condition/halt inputs plus every bus-drive, load and select strobe.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;

  logic PC_out, MDR_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out;

  logic PC_enable, IncPC, MAR_enable, MDR_enable, Read, IR_enable, Y_enable, Z_enable;
  logic HI_enable, LO_enable, CON_enable, RAM_read_enable, RAM_write_enable, Out_port_enable;

  logic       Gra, Grb, Grc, R_in, R_out, BA_out;
  logic [4:0] opcode;
  logic       Run;

  modport master (
    input  IR, CON_FF, Stop,
    output PC_out, MDR_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out,
    output PC_enable, IncPC, MAR_enable, MDR_enable, Read, IR_enable, Y_enable, Z_enable,
    output HI_enable, LO_enable, CON_enable, RAM_read_enable, RAM_write_enable, Out_port_enable,
    output Gra, Grb, Grc, R_in, R_out, BA_out, opcode, Run
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  PC_out, MDR_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out,
    input  PC_enable, IncPC, MAR_enable, MDR_enable, Read, IR_enable, Y_enable, Z_enable,
    input  HI_enable, LO_enable, CON_enable, RAM_read_enable, RAM_write_enable, Out_port_enable,
    input  Gra, Grb, Grc, R_in, R_out, BA_out, opcode, Run
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit: step register T0..T7/HALT, strobes decoded from step and IR[31:27].
// Define CU_IO_EN to enable the in/out port instructions; otherwise they execute as nop.
module control_unit (
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;

  localparam logic [4:0] OP_ADD = 5'b00011;

  step_t      step;
  step_t      last;
  iclass_t    cls;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  always_comb begin
    cls = C_NOP;
    case (op)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = C_ALU;
      5'b01100, 5'b01101, 5'b01110: cls = C_IMM;
      5'b01111, 5'b10000: cls = C_MULDIV;
      5'b10001, 5'b10010: cls = C_UNARY;
      5'b10011: cls = C_BR;
      5'b10100: cls = C_JR;
`ifdef CU_IO_EN
      5'b10101: cls = C_IN;
      5'b10110: cls = C_OUT;
`endif
      5'b10111: cls = C_MFHI;
      5'b11000: cls = C_MFLO;
      5'b11010: cls = C_HALT;
      default:  cls = C_NOP;
    endcase
  end

  always_comb begin
    last = T3;
    case (cls)
      C_ALU, C_IMM, C_LDI: last = T5;
      C_LD, C_ST:          last = T7;
      C_MULDIV, C_BR:      last = T6;
      C_UNARY:             last = T4;
      default:             last = T3;
    endcase
  end

  // Stop is only honoured at an instruction boundary; halt op leaves from T3.
  always_ff @(posedge clk) begin
    if (!clr)
      step <= T0;
    else if (step == HALT)
      step <= HALT;
    else if (step == T3 && cls == C_HALT)
      step <= HALT;
    else if (step == last)
      step <= bus.Stop ? HALT : T0;
    else
      step <= step_t'(step + 4'd1);
  end

  always_comb begin
    bus.PC_out           = 1'b0;
    bus.MDR_out          = 1'b0;
    bus.ZHigh_out        = 1'b0;
    bus.ZLow_out         = 1'b0;
    bus.HI_out           = 1'b0;
    bus.LO_out           = 1'b0;
    bus.In_port_out      = 1'b0;
    bus.C_out            = 1'b0;
    bus.PC_enable        = 1'b0;
    bus.IncPC            = 1'b0;
    bus.MAR_enable       = 1'b0;
    bus.MDR_enable       = 1'b0;
    bus.Read             = 1'b0;
    bus.IR_enable        = 1'b0;
    bus.Y_enable         = 1'b0;
    bus.Z_enable         = 1'b0;
    bus.HI_enable        = 1'b0;
    bus.LO_enable        = 1'b0;
    bus.CON_enable       = 1'b0;
    bus.RAM_read_enable  = 1'b0;
    bus.RAM_write_enable = 1'b0;
    bus.Out_port_enable  = 1'b0;
    bus.Gra              = 1'b0;
    bus.Grb              = 1'b0;
    bus.Grc              = 1'b0;
    bus.R_in             = 1'b0;
    bus.R_out            = 1'b0;
    bus.BA_out           = 1'b0;
    bus.opcode           = '0;
    bus.Run              = clr && (step != HALT);

    if (clr) begin
      case (step)
        T0: begin
          bus.PC_out = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1;
        end
        T1: begin
          bus.RAM_read_enable = 1'b1; bus.Read = 1'b1; bus.MDR_enable = 1'b1;
        end
        T2: begin
          bus.MDR_out = 1'b1; bus.IR_enable = 1'b1;
        end
        HALT: ;
        default: begin
          case (cls)
            C_ALU, C_IMM: begin
              case (step)
                T3: begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
                T4: begin
                  if (cls == C_IMM) bus.C_out = 1'b1;
                  else begin bus.Grc = 1'b1; bus.R_out = 1'b1; end
                  bus.opcode = op; bus.Z_enable = 1'b1;
                end
                T5: begin bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                default: ;
              endcase
            end
            C_MULDIV: begin
              case (step)
                T3: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
                T4: begin
                  bus.Grb = 1'b1; bus.R_out = 1'b1; bus.opcode = op; bus.Z_enable = 1'b1;
                end
                T5: begin bus.ZLow_out = 1'b1; bus.LO_enable = 1'b1; end
                T6: begin bus.ZHigh_out = 1'b1; bus.HI_enable = 1'b1; end
                default: ;
              endcase
            end
            C_UNARY: begin
              case (step)
                T3: begin
                  bus.Grb = 1'b1; bus.R_out = 1'b1; bus.opcode = op; bus.Z_enable = 1'b1;
                end
                T4: begin bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                default: ;
              endcase
            end
            C_LD, C_LDI, C_ST: begin
              case (step)
                T3: begin bus.Grb = 1'b1; bus.BA_out = 1'b1; bus.Y_enable = 1'b1; end
                T4: begin bus.C_out = 1'b1; bus.opcode = OP_ADD; bus.Z_enable = 1'b1; end
                T5: begin
                  bus.ZLow_out = 1'b1;
                  if (cls == C_LDI) begin bus.Gra = 1'b1; bus.R_in = 1'b1; end
                  else bus.MAR_enable = 1'b1;
                end
                T6: begin
                  bus.MDR_enable = 1'b1;
                  if (cls == C_LD) begin bus.RAM_read_enable = 1'b1; bus.Read = 1'b1; end
                  else begin bus.Gra = 1'b1; bus.R_out = 1'b1; end
                end
                T7: begin
                  if (cls == C_LD) begin bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                  else bus.RAM_write_enable = 1'b1;
                end
                default: ;
              endcase
            end
            C_BR: begin
              case (step)
                T3: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.CON_enable = 1'b1; end
                T4: begin bus.PC_out = 1'b1; bus.Y_enable = 1'b1; end
                T5: begin bus.C_out = 1'b1; bus.opcode = OP_ADD; bus.Z_enable = 1'b1; end
                T6: begin bus.ZLow_out = 1'b1; bus.PC_enable = bus.CON_FF; end
                default: ;
              endcase
            end
            C_JR: if (step == T3) begin
              bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1;
            end
            C_MFHI: if (step == T3) begin
              bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
            end
            C_MFLO: if (step == T3) begin
              bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
            end
`ifdef CU_IO_EN
            C_IN: if (step == T3) begin
              bus.In_port_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
            end
            C_OUT: if (step == T3) begin
              bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Out_port_enable = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step strobe vectors compared against hand-built masks.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr;
  control_unit_if bus ();

  control_unit dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [27:0] M_PC_OUT  = 28'd1 << 27;
  localparam logic [27:0] M_MDR_OUT = 28'd1 << 26;
  localparam logic [27:0] M_ZHI_OUT = 28'd1 << 25;
  localparam logic [27:0] M_ZLO_OUT = 28'd1 << 24;
  localparam logic [27:0] M_HI_OUT  = 28'd1 << 23;
  localparam logic [27:0] M_LO_OUT  = 28'd1 << 22;
  localparam logic [27:0] M_IN_OUT  = 28'd1 << 21;
  localparam logic [27:0] M_C_OUT   = 28'd1 << 20;
  localparam logic [27:0] M_PC_EN   = 28'd1 << 19;
  localparam logic [27:0] M_INCPC   = 28'd1 << 18;
  localparam logic [27:0] M_MAR_EN  = 28'd1 << 17;
  localparam logic [27:0] M_MDR_EN  = 28'd1 << 16;
  localparam logic [27:0] M_READ    = 28'd1 << 15;
  localparam logic [27:0] M_IR_EN   = 28'd1 << 14;
  localparam logic [27:0] M_Y_EN    = 28'd1 << 13;
  localparam logic [27:0] M_Z_EN    = 28'd1 << 12;
  localparam logic [27:0] M_HI_EN   = 28'd1 << 11;
  localparam logic [27:0] M_LO_EN   = 28'd1 << 10;
  localparam logic [27:0] M_CON_EN  = 28'd1 << 9;
  localparam logic [27:0] M_RAM_RD  = 28'd1 << 8;
  localparam logic [27:0] M_RAM_WR  = 28'd1 << 7;
  localparam logic [27:0] M_OUTP_EN = 28'd1 << 6;
  localparam logic [27:0] M_GRA     = 28'd1 << 5;
  localparam logic [27:0] M_GRB     = 28'd1 << 4;
  localparam logic [27:0] M_GRC     = 28'd1 << 3;
  localparam logic [27:0] M_R_IN    = 28'd1 << 2;
  localparam logic [27:0] M_R_OUT   = 28'd1 << 1;
  localparam logic [27:0] M_BA_OUT  = 28'd1 << 0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [33:0] ev [8];

  function automatic logic [33:0] e(logic [4:0] opc, logic [27:0] m);
    return {1'b1, opc, m};
  endfunction

  function automatic logic [33:0] obs();
    return {bus.Run, bus.opcode,
            bus.PC_out, bus.MDR_out, bus.ZHigh_out, bus.ZLow_out, bus.HI_out, bus.LO_out,
            bus.In_port_out, bus.C_out, bus.PC_enable, bus.IncPC, bus.MAR_enable, bus.MDR_enable,
            bus.Read, bus.IR_enable, bus.Y_enable, bus.Z_enable, bus.HI_enable, bus.LO_enable,
            bus.CON_enable, bus.RAM_read_enable, bus.RAM_write_enable, bus.Out_port_enable,
            bus.Gra, bus.Grb, bus.Grc, bus.R_in, bus.R_out, bus.BA_out};
  endfunction

  task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  logic [33:0] F0, F1, F2;

  task automatic do_reset(input string tag);
    @(negedge clk);
    clr = 1'b0;
    #1 check_eq({tag, "_held"}, obs(), 34'h0);
    @(negedge clk);
    #1 check_eq({tag, "_still"}, obs(), 34'h0);
    clr = 1'b1;
    #1 check_eq({tag, "_rel_T0"}, obs(), F0);
  endtask

  // Steps through ev[0..n-1]; Stop rises at step stop_at (-1 = never); 'after' is the next step's view.
  task automatic run_seq(input string tag, input logic [4:0] op, input int n,
                         input int stop_at, input logic [33:0] after);
    bus.IR = {op, 27'h2A5_5A5A};
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) bus.Stop = 1'b1;
      #1 check_eq($sformatf("%s_T%0d", tag, i), obs(), ev[i]);
      @(negedge clk);
    end
    #1 check_eq({tag, "_next"}, obs(), after);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    F0 = e(5'd0, M_PC_OUT | M_MAR_EN | M_INCPC);
    F1 = e(5'd0, M_RAM_RD | M_READ | M_MDR_EN);
    F2 = e(5'd0, M_MDR_OUT | M_IR_EN);
    clr = 1'b0; bus.IR = '0; bus.CON_FF = 1'b0; bus.Stop = 1'b0;
    ev[0] = F0; ev[1] = F1; ev[2] = F2;

    do_reset("rst");

    // add R3,R1,R2
    ev[3] = e(5'd0, M_GRB | M_R_OUT | M_Y_EN);
    ev[4] = e(5'b00011, M_GRC | M_R_OUT | M_Z_EN);
    ev[5] = e(5'd0, M_ZLO_OUT | M_GRA | M_R_IN);
    run_seq("add", 5'b00011, 6, -1, F0);

    // addi
    ev[4] = e(5'b01100, M_C_OUT | M_Z_EN);
    run_seq("addi", 5'b01100, 6, -1, F0);

    // ld
    ev[3] = e(5'd0, M_GRB | M_BA_OUT | M_Y_EN);
    ev[4] = e(5'b00011, M_C_OUT | M_Z_EN);
    ev[5] = e(5'd0, M_ZLO_OUT | M_MAR_EN);
    ev[6] = e(5'd0, M_RAM_RD | M_READ | M_MDR_EN);
    ev[7] = e(5'd0, M_MDR_OUT | M_GRA | M_R_IN);
    run_seq("ld", 5'b00000, 8, -1, F0);

    // ldi
    ev[5] = e(5'd0, M_ZLO_OUT | M_GRA | M_R_IN);
    run_seq("ldi", 5'b00001, 6, -1, F0);

    // st
    ev[5] = e(5'd0, M_ZLO_OUT | M_MAR_EN);
    ev[6] = e(5'd0, M_GRA | M_R_OUT | M_MDR_EN);
    ev[7] = e(5'd0, M_RAM_WR);
    run_seq("st", 5'b00010, 8, -1, F0);

    // br taken / not taken
    ev[3] = e(5'd0, M_GRA | M_R_OUT | M_CON_EN);
    ev[4] = e(5'd0, M_PC_OUT | M_Y_EN);
    ev[5] = e(5'b00011, M_C_OUT | M_Z_EN);
    ev[6] = e(5'd0, M_ZLO_OUT | M_PC_EN);
    bus.CON_FF = 1'b1;
    run_seq("br1", 5'b10011, 7, -1, F0);
    ev[6] = e(5'd0, M_ZLO_OUT);
    bus.CON_FF = 1'b0;
    run_seq("br0", 5'b10011, 7, -1, F0);

    // mul
    ev[3] = e(5'd0, M_GRA | M_R_OUT | M_Y_EN);
    ev[4] = e(5'b01111, M_GRB | M_R_OUT | M_Z_EN);
    ev[5] = e(5'd0, M_ZLO_OUT | M_LO_EN);
    ev[6] = e(5'd0, M_ZHI_OUT | M_HI_EN);
    run_seq("mul", 5'b01111, 7, -1, F0);

    // neg
    ev[3] = e(5'b10001, M_GRB | M_R_OUT | M_Z_EN);
    ev[4] = e(5'd0, M_ZLO_OUT | M_GRA | M_R_IN);
    run_seq("neg", 5'b10001, 5, -1, F0);

    // single-step instructions
    ev[3] = e(5'd0, M_GRA | M_R_OUT | M_PC_EN);
    run_seq("jr", 5'b10100, 4, -1, F0);
    ev[3] = e(5'd0, M_HI_OUT | M_GRA | M_R_IN);
    run_seq("mfhi", 5'b10111, 4, -1, F0);
    ev[3] = e(5'd0, M_LO_OUT | M_GRA | M_R_IN);
    run_seq("mflo", 5'b11000, 4, -1, F0);
`ifdef CU_IO_EN
    ev[3] = e(5'd0, M_IN_OUT | M_GRA | M_R_IN);
`else
    ev[3] = e(5'd0, 28'd0);
`endif
    run_seq("in", 5'b10101, 4, -1, F0);
`ifdef CU_IO_EN
    ev[3] = e(5'd0, M_GRA | M_R_OUT | M_OUTP_EN);
`else
    ev[3] = e(5'd0, 28'd0);
`endif
    run_seq("out", 5'b10110, 4, -1, F0);
    ev[3] = e(5'd0, 28'd0);
    run_seq("undef", 5'b11101, 4, -1, F0);

    // st aborted by reset in T6
    ev[3] = e(5'd0, M_GRB | M_BA_OUT | M_Y_EN);
    ev[4] = e(5'b00011, M_C_OUT | M_Z_EN);
    ev[5] = e(5'd0, M_ZLO_OUT | M_MAR_EN);
    ev[6] = e(5'd0, M_GRA | M_R_OUT | M_MDR_EN);
    run_seq("st_ab", 5'b00010, 6, -1, ev[6]);
    clr = 1'b0;
    #1 check_eq("st_ab_clr_T6", obs(), 34'h0);
    @(negedge clk);
    #1 check_eq("st_ab_clr_T7slot", obs(), 34'h0);
    clr = 1'b1;
    #1 check_eq("st_ab_rel_T0", obs(), F0);

    // Stop raised in T4 of add: add completes, then halt
    ev[3] = e(5'd0, M_GRB | M_R_OUT | M_Y_EN);
    ev[4] = e(5'b00011, M_GRC | M_R_OUT | M_Z_EN);
    ev[5] = e(5'd0, M_ZLO_OUT | M_GRA | M_R_IN);
    run_seq("stop", 5'b00011, 6, 4, 34'h0);
    bus.Stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1 check_eq($sformatf("stop_halt%0d", i), obs(), 34'h0);
    end
    do_reset("stop_rst");

    // halt instruction
    ev[3] = e(5'd0, 28'd0);
    run_seq("halt", 5'b11010, 4, -1, 34'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1 check_eq($sformatf("halt_hold%0d", i), obs(), 34'h0);
    end
    do_reset("halt_rst");
    @(negedge clk);
    #1 check_eq("halt_rst_T1", obs(), F1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; clr  in  1  synchronous active-low reset.
REQ-002 SHALL have inputs: IR  in  32  instruction register contents; CON_FF  in  1  branch condition; Stop  in  1  halt request.
REQ-003 SHALL have bus-drive outputs, 1 bit each: PC_out, MDR_out, ZHigh_out, ZLow_out, HI_out, LO_out, In_port_out, C_out.
REQ-004 SHALL have load outputs, 1 bit each: PC_enable, IncPC, MAR_enable, MDR_enable, Read, IR_enable, Y_enable, Z_enable, HI_enable, LO_enable, CON_enable, RAM_read_enable, RAM_write_enable, Out_port_enable.
REQ-005 SHALL have register-select outputs, 1 bit each: Gra, Grb, Grc, R_in, R_out, BA_out; and opcode  out  5  ALU operation.
REQ-006 SHALL have output Run  out  1, high while not halted.

Function
REQ-007 SHALL hold a step register T0..T7 plus HALT; outputs are decoded combinationally from step and IR[31:27] (op); unlisted outputs are 0.
REQ-008 Fetch SHALL be: T0 PC_out, MAR_enable, IncPC; T1 RAM_read_enable, Read, MDR_enable; T2 MDR_out, IR_enable.
REQ-009 Opcode map: 00000 ld; 00001 ldi; 00010 st; 00011-01011 three-register ALU; 01100-01110 immediate ALU; 01111 mul; 10000 div; 10001 neg; 10010 not; 10011 br; 10100 jr; 10101 in; 10110 out; 10111 mfhi; 11000 mflo; 11001 nop; 11010 halt; 11011-11111 undefined, executed as nop.
REQ-010 Three-register ALU SHALL be: T3 Grb, R_out, Y_enable; T4 Grc, R_out, opcode=op, Z_enable; T5 ZLow_out, Gra, R_in.
REQ-011 Immediate ALU SHALL be the REQ-010 sequence with T4 using C_out in place of Grc, R_out.
REQ-012 mul/div SHALL be: T3 Gra, R_out, Y_enable; T4 Grb, R_out, opcode=op, Z_enable; T5 ZLow_out, LO_enable; T6 ZHigh_out, HI_enable.
REQ-013 neg/not SHALL be: T3 Grb, R_out, opcode=op, Z_enable; T4 ZLow_out, Gra, R_in.
REQ-014 ld/ldi/st SHALL share: T3 Grb, BA_out, Y_enable; T4 C_out, opcode=00011, Z_enable.
REQ-015 ldi SHALL then do: T5 ZLow_out, Gra, R_in.
REQ-016 ld SHALL then do: T5 ZLow_out, MAR_enable; T6 RAM_read_enable, Read, MDR_enable; T7 MDR_out, Gra, R_in.
REQ-017 st SHALL then do: T5 ZLow_out, MAR_enable; T6 Gra, R_out, MDR_enable with Read=0; T7 RAM_write_enable.
REQ-018 br SHALL be: T3 Gra, R_out, CON_enable; T4 PC_out, Y_enable; T5 C_out, opcode=00011, Z_enable; T6 ZLow_out, with PC_enable equal to CON_FF sampled in T6.
REQ-019 jr SHALL be T3 Gra, R_out, PC_enable; mfhi SHALL be T3 HI_out, Gra, R_in; mflo SHALL be T3 LO_out, Gra, R_in; nop SHALL be T3 with no outputs asserted.
REQ-020 After an instruction's last step, the next step SHALL be T0.
REQ-021 halt SHALL enter HALT from T3.
REQ-022 Stop high when the next step would be T0 SHALL enter HALT instead; Stop in any other step SHALL have no effect until the instruction completes.
REQ-023 HALT SHALL assert no outputs, hold Run=0, and be exited only by reset.
REQ-024 At most one *_out SHALL be asserted in any cycle.

Reset
REQ-025 While clr=0 at a rising edge, the step register SHALL become T0, aborting any instruction mid-sequence.
REQ-026 While clr=0, all outputs SHALL be forced to 0, including Run and the write strobes.
REQ-027 The first cycle with clr=1 SHALL execute T0 with Run=1.

Configuration
REQ-028 With CU_IO_EN defined: in SHALL be T3 In_port_out, Gra, R_in; out SHALL be T3 Gra, R_out, Out_port_enable.
REQ-029 Without CU_IO_EN: in and out SHALL execute as nop, In_port_out and Out_port_enable SHALL be tied 0, and the port list SHALL be unchanged.

Verification
REQ-030 Reset then release, IR=add R3,R1,R2 (op 00011): T0-T2 fetch strobes, T5 asserts ZLow_out, Gra, R_in; T0 recurs 6 cycles after start.
REQ-031 IR=ld (op 00000): RAM_read_enable is asserted in T1 and T6; MDR_out, Gra, R_in in T7; the next instruction's T0 follows on cycle 9.
REQ-032 IR=br (op 10011): with CON_FF=1 in T6, PC_enable=1 in T6; repeat with CON_FF=0, PC_enable stays 0 throughout.
REQ-033 clr driven low during T6 of st: RAM_write_enable never asserts; after release the step is T0.
REQ-034 IR=halt, and separately Stop=1 during T4 of add: Run drops after the add completes; all outputs stay 0 for 20 cycles; only reset resumes execution.
REQ-035 IR=in (op 10101) with and without CU_IO_EN: In_port_out and R_in are asserted in T3 only when the macro is defined.
